// File: rtl/voice_scheduler_pkg.sv
// Shared synth constants and types for the voice scheduler slice.
// Widths here are the defaults the scheduler and its allocator are built with.
package voice_scheduler_pkg;

  localparam int unsigned SYNTH_PHASE_ACC_BITS = 32;
  localparam int unsigned SYNTH_WIDTH          = 24;
  localparam int unsigned VOICE_COUNT          = 8;
  localparam int unsigned VOICE_KEY_BITS       = 7;

  typedef struct packed {
    logic                            active;
    logic [VOICE_KEY_BITS-1:0]       key;
    logic [SYNTH_PHASE_ACC_BITS-1:0] incr;
    logic [SYNTH_PHASE_ACC_BITS-1:0] phase;
  } voice_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } sched_state_t;

endpackage

// File: rtl/voice_alloc.sv
// Combinational voice lookup: finds the active voice holding a key and the
// lowest-index inactive voice. Keys are unique among active voices.
module voice_alloc import voice_scheduler_pkg::*; #(
  parameter int unsigned NUM_VOICES = VOICE_COUNT,
  parameter int unsigned KEY_BITS   = VOICE_KEY_BITS,
  localparam int unsigned IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]               active_in,
  input  logic [NUM_VOICES-1:0][KEY_BITS-1:0] keys_in,
  input  logic [KEY_BITS-1:0]                 key_in,
  output logic                                hit_out,
  output logic [IDX_W-1:0]                    hit_idx_out,
  output logic                                free_out,
  output logic [IDX_W-1:0]                    free_idx_out
);

  always_comb begin
    hit_out      = 1'b0;
    hit_idx_out  = '0;
    free_out     = 1'b0;
    free_idx_out = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!hit_out && active_in[i] && (keys_in[i] == key_in)) begin
        hit_out     = 1'b1;
        hit_idx_out = IDX_W'(i);
      end
      if (!free_out && !active_in[i]) begin
        free_out     = 1'b1;
        free_idx_out = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: shares one oscillator lookup path among all
// active voices and produces one saturated mix sample per sample tick.
module voice_scheduler import voice_scheduler_pkg::*; #(
  parameter int unsigned NUM_VOICES   = VOICE_COUNT,
  parameter int unsigned PHASE_BITS   = SYNTH_PHASE_ACC_BITS,
  parameter int unsigned SAMPLE_WIDTH = SYNTH_WIDTH,
  parameter int unsigned KEY_BITS     = VOICE_KEY_BITS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sample_tick_in,
  input  logic                    note_on_in,
  input  logic                    note_off_in,
  input  logic [KEY_BITS-1:0]     note_key_in,
  input  logic [PHASE_BITS-1:0]   note_incr_in,
  output logic                    osc_req_out,
  output logic [PHASE_BITS-1:0]   osc_phase_out,
  input  logic                    osc_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] osc_sample_in,
  output logic [SAMPLE_WIDTH-1:0] mix_out,
  output logic                    mix_valid_out,
  output logic [NUM_VOICES-1:0]   active_out,
  output logic                    voice_full_out,
  output logic                    tick_miss_out
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam int unsigned ACC_W = SAMPLE_WIDTH + IDX_W;

  sched_state_t                        state_q;
  logic [IDX_W-1:0]                    idx_q;
  logic signed [ACC_W-1:0]             acc_q;
  logic [NUM_VOICES-1:0]               active_q;
  logic [NUM_VOICES-1:0][KEY_BITS-1:0] key_q;
  logic [PHASE_BITS-1:0]               incr_q  [NUM_VOICES];
  logic [PHASE_BITS-1:0]               phase_q [NUM_VOICES];
  logic [SAMPLE_WIDTH-1:0]             mix_q;
  logic                                mix_valid_q;
  logic                                voice_full_q;
  logic                                tick_miss_q;

  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    free;
  logic [IDX_W-1:0]        free_idx;
  logic                    last_voice;
  logic                    osc_req;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_final;
  logic [SAMPLE_WIDTH-1:0] acc_sat;
  logic                    on_claim;
  logic [IDX_W-1:0]        on_idx;
  logic                    on_full;

  voice_alloc #(
    .NUM_VOICES (NUM_VOICES),
    .KEY_BITS   (KEY_BITS)
  ) u_voice_alloc (
    .active_in    (active_q),
    .keys_in      (key_q),
    .key_in       (note_key_in),
    .hit_out      (hit),
    .hit_idx_out  (hit_idx),
    .free_out     (free),
    .free_idx_out (free_idx)
  );

  always_comb begin
    last_voice = (idx_q == IDX_W'(NUM_VOICES - 1));
    osc_req    = (state_q == StIssue) && active_q[idx_q];
    sample_ext = {{IDX_W{osc_sample_in[SAMPLE_WIDTH-1]}}, osc_sample_in};
    acc_sum    = acc_q + sample_ext;
    acc_final  = ((state_q == StWait) && osc_valid_in) ? acc_sum : acc_q;

    // Out of range when the bits above the sample's sign bit disagree with it.
    if (acc_final[ACC_W-1] && !(&acc_final[ACC_W-1:SAMPLE_WIDTH-1])) begin
      acc_sat = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    end else if (!acc_final[ACC_W-1] && (|acc_final[ACC_W-1:SAMPLE_WIDTH-1])) begin
      acc_sat = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end else begin
      acc_sat = acc_final[SAMPLE_WIDTH-1:0];
    end

    // Off and on share the key, so a simultaneous off frees the hit voice;
    // the on then claims whichever of it and the lowest free voice is lower.
    on_claim = 1'b0;
    on_idx   = free_idx;
    on_full  = 1'b0;
    if (hit && !note_off_in) begin
      on_idx = hit_idx;
    end else if (hit) begin
      on_claim = 1'b1;
      on_idx   = (free && (free_idx < hit_idx)) ? free_idx : hit_idx;
    end else if (free) begin
      on_claim = 1'b1;
    end else begin
      on_full = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      acc_q        <= '0;
      active_q     <= '0;
      key_q        <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        incr_q[i]  <= '0;
        phase_q[i] <= '0;
      end
      mix_q        <= '0;
      mix_valid_q  <= 1'b0;
      voice_full_q <= 1'b0;
      tick_miss_q  <= 1'b0;
    end else begin
      mix_valid_q  <= 1'b0;
      voice_full_q <= 1'b0;
      tick_miss_q  <= sample_tick_in && (state_q != StIdle);

      unique case (state_q)
        StIdle: begin
          if (sample_tick_in) begin
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (active_q[idx_q]) begin
            phase_q[idx_q] <= phase_q[idx_q] + incr_q[idx_q];
            state_q        <= StWait;
          end else if (last_voice) begin
            mix_q       <= acc_sat;
            mix_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StWait: begin
          if (osc_valid_in) begin
            acc_q <= acc_sum;
            if (last_voice) begin
              mix_q       <= acc_sat;
              mix_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= StIssue;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // Note writes come last so a retrigger wins over a same-cycle phase advance.
      if (note_off_in && hit) begin
        active_q[hit_idx] <= 1'b0;
      end
      if (note_on_in) begin
        if (on_full) begin
          voice_full_q <= 1'b1;
        end else begin
          incr_q[on_idx]  <= note_incr_in;
          phase_q[on_idx] <= '0;
          if (on_claim) begin
            active_q[on_idx] <= 1'b1;
            key_q[on_idx]    <= note_key_in;
          end
        end
      end
    end
  end

  assign osc_req_out    = osc_req;
  assign osc_phase_out  = osc_req ? phase_q[idx_q] : '0;
  assign mix_out        = mix_q;
  assign mix_valid_out  = mix_valid_q;
  assign active_out     = active_q;
  assign voice_full_out = voice_full_q;
  assign tick_miss_out  = tick_miss_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler (4 voices) with a 2-cycle stub
// oscillator that returns phase[31:8] as the sample.
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic [6:0]  note_key = '0;
  logic [31:0] note_incr = '0;
  logic        osc_req;
  logic [31:0] osc_phase;
  logic        osc_valid;
  logic [23:0] osc_sample;
  logic [23:0] mix;
  logic        mix_valid;
  logic [3:0]  active;
  logic        voice_full;
  logic        tick_miss;

  logic [1:0]  vpipe = '0;
  logic [23:0] d0 = '0;
  logic [23:0] d1 = '0;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_mix_q[$];
  logic [31:0] exp_phase_q[$];

  voice_scheduler #(
    .NUM_VOICES   (4),
    .PHASE_BITS   (32),
    .SAMPLE_WIDTH (24),
    .KEY_BITS     (7)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .sample_tick_in (sample_tick),
    .note_on_in     (note_on),
    .note_off_in    (note_off),
    .note_key_in    (note_key),
    .note_incr_in   (note_incr),
    .osc_req_out    (osc_req),
    .osc_phase_out  (osc_phase),
    .osc_valid_in   (osc_valid),
    .osc_sample_in  (osc_sample),
    .mix_out        (mix),
    .mix_valid_out  (mix_valid),
    .active_out     (active),
    .voice_full_out (voice_full),
    .tick_miss_out  (tick_miss)
  );

  always #5 clk = ~clk;

  // Stub oscillator, latency 2; deliberately not reset so late results can appear.
  always @(posedge clk) begin
    vpipe <= {vpipe[0], osc_req === 1'b1};
    d0    <= osc_phase[31:8];
    d1    <= d0;
  end
  assign osc_valid  = vpipe[1];
  assign osc_sample = d1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or a mix.
  always @(negedge clk) begin
    if (osc_req === 1'b1) begin
      if (exp_phase_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL osc_req: got request phase 0x%0h, required no request", osc_phase);
      end else begin
        check("osc_phase", osc_phase, exp_phase_q.pop_front());
      end
    end
    if (mix_valid === 1'b1) begin
      if (exp_mix_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mix_valid: got mix 0x%0h, required no mix", mix);
      end else begin
        check("mix_out", {8'h0, mix}, {8'h0, exp_mix_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mix", {8'h0, mix}, 32'h0);
    check("rst_flags", {28'h0, mix_valid, osc_req, voice_full, tick_miss}, 32'h0);
    check("rst_active", {28'h0, active}, 32'h0);
    check("rst_phase", osc_phase, 32'h0);
  endtask

  task automatic note(input logic on, input logic off, input logic [6:0] key,
                      input logic [31:0] incr);
    @(negedge clk);
    note_on   = on;
    note_off  = off;
    note_key  = key;
    note_incr = incr;
    @(negedge clk);
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  task automatic push_phases(input logic [31:0] p0, input logic [31:0] p1,
                             input logic [31:0] p2, input logic [31:0] p3, input int cnt);
    if (cnt > 0) exp_phase_q.push_back(p0);
    if (cnt > 1) exp_phase_q.push_back(p1);
    if (cnt > 2) exp_phase_q.push_back(p2);
    if (cnt > 3) exp_phase_q.push_back(p3);
  endtask

  // One frame: tick, optionally a stray tick at cycle miss_at, measure frame length.
  task automatic frame(input string name, input logic [23:0] exp_mix, input int exp_len,
                       input int miss_at);
    int n;
    exp_mix_q.push_back(exp_mix);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n = 1;
    while (mix_valid !== 1'b1 && n < 200) begin
      if (miss_at != 0 && n == miss_at) sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      n++;
      if (miss_at != 0 && n == miss_at + 1) check({name, "_tick_miss"}, {31'h0, tick_miss}, 1);
    end
    check({name, "_len"}, n, exp_len);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_active", {28'h0, active}, 32'h0);
    check("init_mix", {8'h0, mix}, 32'h0);

    // Empty frame: no requests, mix 0 at cycle N+1.
    frame("idle", 24'h0, 5, 0);

    // Single voice advancing its phase.
    note(1, 0, 7'd60, 32'h100);
    check("one_active", {28'h0, active}, 32'h1);
    push_phases(32'h0, 0, 0, 0, 1);
    frame("one_f0", 24'h0, 7, 0);
    push_phases(32'h100, 0, 0, 0, 1);
    frame("one_f1", 24'h1, 7, 0);
    push_phases(32'h200, 0, 0, 0, 1);
    frame("one_f2", 24'h2, 7, 0);

    // Allocation, full table, reuse of a freed slot.
    do_reset();
    for (int k = 1; k <= 4; k++) note(1, 0, 7'(k), 32'h0);
    check("alloc_no_full", {31'h0, voice_full}, 0);
    check("alloc_active4", {28'h0, active}, 32'hF);
    note(1, 0, 7'd5, 32'h500);
    check("alloc_full", {31'h0, voice_full}, 1);
    check("alloc_full_active", {28'h0, active}, 32'hF);
    note(0, 1, 7'd2, 32'h0);
    check("alloc_off2", {28'h0, active}, 32'hD);
    note(1, 0, 7'd5, 32'h500);
    check("alloc_reuse", {28'h0, active}, 32'hF);
    push_phases(32'h0, 32'h0, 32'h0, 32'h0, 4);
    frame("alloc_f0", 24'h0, 13, 0);
    push_phases(32'h0, 32'h500, 32'h0, 32'h0, 4);
    frame("alloc_f1", 24'h5, 13, 0);

    // Positive saturation.
    do_reset();
    for (int k = 1; k <= 4; k++) note(1, 0, 7'(k), 32'h7FFF_FF00);
    push_phases(32'h0, 32'h0, 32'h0, 32'h0, 4);
    frame("psat_f0", 24'h0, 13, 0);
    push_phases(32'h7FFF_FF00, 32'h7FFF_FF00, 32'h7FFF_FF00, 32'h7FFF_FF00, 4);
    frame("psat_f1", 24'h7F_FFFF, 13, 0);

    // Negative saturation, then phase wrap back to 0.
    do_reset();
    for (int k = 1; k <= 4; k++) note(1, 0, 7'(k), 32'h8000_0000);
    push_phases(32'h0, 32'h0, 32'h0, 32'h0, 4);
    frame("nsat_f0", 24'h0, 13, 0);
    push_phases(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4);
    frame("nsat_f1", 24'h80_0000, 13, 0);
    push_phases(32'h0, 32'h0, 32'h0, 32'h0, 4);
    frame("nsat_wrap", 24'h0, 13, 0);

    // Mixed signs: 0x7FFFFF + (-0x800000) = -1.
    do_reset();
    note(1, 0, 7'd10, 32'h7FFF_FF00);
    note(1, 0, 7'd11, 32'h8000_0000);
    push_phases(32'h0, 32'h0, 0, 0, 2);
    frame("mixed_f0", 24'h0, 9, 0);
    push_phases(32'h7FFF_FF00, 32'h8000_0000, 0, 0, 2);
    frame("mixed_f1", 24'hFF_FFFF, 9, 0);

    // Simultaneous off+on retriggers; a stray mid-frame tick is reported and ignored.
    do_reset();
    note(1, 0, 7'd9, 32'h100);
    push_phases(32'h0, 0, 0, 0, 1);
    frame("retrig_f0", 24'h0, 7, 0);
    push_phases(32'h100, 0, 0, 0, 1);
    frame("retrig_f1", 24'h1, 7, 0);
    note(1, 1, 7'd9, 32'h300);
    check("retrig_active", {28'h0, active}, 32'h1);
    push_phases(32'h0, 0, 0, 0, 1);
    frame("retrig_f2", 24'h0, 7, 0);
    push_phases(32'h300, 0, 0, 0, 1);
    frame("retrig_miss", 24'h3, 7, 2);

    // Reset during WAIT, late oscillator result must be ignored.
    note(0, 1, 7'd9, 32'h0);
    note(1, 0, 7'd3, 32'h100);
    push_phases(32'h0, 0, 0, 0, 1);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_mix", {8'h0, mix}, 32'h0);
    check("abort_active", {28'h0, active}, 32'h0);
    check("abort_flags", {28'h0, mix_valid, osc_req, voice_full, tick_miss}, 32'h0);
    repeat (10) @(negedge clk);
    note(1, 0, 7'd3, 32'h200);
    push_phases(32'h0, 0, 0, 0, 1);
    frame("post_abort_f0", 24'h0, 7, 0);
    push_phases(32'h200, 0, 0, 0, 1);
    frame("post_abort_f1", 24'h2, 7, 0);

    repeat (3) @(negedge clk);
    check("left_mix", exp_mix_q.size(), 0);
    check("left_phase", exp_phase_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
